// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_ctrl_fsm_pkg: shared state encodings, RV32I opcode constants and the
// control-strobe bundle for the multicycle control FSM.
package mc_ctrl_fsm_pkg;

    localparam int ST_ENC_W = 4;

    localparam logic [3:0] ST_IF1  = 4'd0;
    localparam logic [3:0] ST_IF2  = 4'd1;
    localparam logic [3:0] ST_ID   = 4'd2;
    localparam logic [3:0] ST_EX1  = 4'd3;
    localparam logic [3:0] ST_EX2  = 4'd4;
    localparam logic [3:0] ST_MEM  = 4'd5;
    localparam logic [3:0] ST_WB   = 4'd6;
    localparam logic [3:0] ST_HALT = 4'd7;
    localparam logic [3:0] ST_ERR  = 4'd8;

    localparam logic [6:0] ARITHMETIC     = 7'b0110011;
    localparam logic [6:0] ARITHMETIC_IMM = 7'b0010011;
    localparam logic [6:0] LOAD           = 7'b0000011;
    localparam logic [6:0] STORE          = 7'b0100011;
    localparam logic [6:0] BRANCH         = 7'b1100011;
    localparam logic [6:0] JAL            = 7'b1101111;
    localparam logic [6:0] JALR           = 7'b1100111;
    localparam logic [6:0] ECALL          = 7'b1110011;
    localparam logic [6:0] LUI            = 7'b0110111;
    localparam logic [6:0] AUIPC          = 7'b0010111;

    typedef struct packed {
        logic ir_write;
        logic mem_req;
        logic mem_we;
        logic rf_we;
        logic pc_write;
        logic retire;
    } ctrl_strb_t;

    // Opcodes that go through the decode state after the fetch completes.
    function automatic logic needs_decode(input logic [6:0] op);
        case (op)
            ARITHMETIC, ARITHMETIC_IMM, LOAD, STORE,
            BRANCH, JALR, LUI, AUIPC: needs_decode = 1'b1;
            default:                 needs_decode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_next_state.sv
// mc_ctrl_next_state: purely combinational next-state and control-strobe
// logic for the multicycle control FSM. No storage lives here.
module mc_ctrl_next_state
    import mc_ctrl_fsm_pkg::*;
(
    input  logic [3:0] state,
    input  logic [6:0] opcode,
    input  logic       alu_bcond,
    input  logic       mem_ready,
    input  logic       timeout_hit,
    output logic [3:0] next_state,
    output ctrl_strb_t strb
);

    // Next state and strobes; retire flags any entry into IF1 or HALT.
    always_comb begin
        next_state = state;
        strb       = '0;
        case (state)
            ST_IF1: begin
                strb.mem_req = 1'b1;
                next_state   = ST_IF2;
            end
            ST_IF2: begin
                strb.mem_req = 1'b1;
                if (mem_ready) begin
                    strb.ir_write = 1'b1;
                    if (opcode == ECALL)      next_state = ST_HALT;
                    else if (opcode == JAL)   next_state = ST_EX1;
                    else if (needs_decode(opcode)) next_state = ST_ID;
                    else                      next_state = ST_ERR;
                end else if (timeout_hit) begin
                    next_state = ST_ERR;
                end
            end
            ST_ID: next_state = ST_EX1;
            ST_EX1: begin
                case (opcode)
                    BRANCH: begin
                        if (alu_bcond) begin
                            next_state = ST_EX2;
                        end else begin
                            strb.pc_write = 1'b1;
                            next_state    = ST_IF1;
                        end
                    end
                    ARITHMETIC, ARITHMETIC_IMM, JAL, JALR, LUI, AUIPC:
                        next_state = ST_WB;
                    LOAD, STORE: next_state = ST_MEM;
                    default:     next_state = ST_ERR;
                endcase
            end
            ST_EX2: begin
                strb.pc_write = 1'b1;
                next_state    = ST_IF1;
            end
            ST_MEM: begin
                strb.mem_req = 1'b1;
                strb.mem_we  = (opcode == STORE);
                if (mem_ready) begin
                    if (opcode == LOAD) begin
                        next_state = ST_WB;
                    end else if (opcode == STORE) begin
                        strb.pc_write = 1'b1;
                        next_state    = ST_IF1;
                    end else begin
                        next_state = ST_ERR;
                    end
                end else if (timeout_hit) begin
                    next_state = ST_ERR;
                end
            end
            ST_WB: begin
                strb.rf_we    = 1'b1;
                strb.pc_write = 1'b1;
                next_state    = ST_IF1;
            end
            ST_HALT: next_state = ST_HALT;
            ST_ERR:  next_state = ST_ERR;
            default: next_state = ST_ERR;
        endcase
        strb.retire = (next_state != state) &&
                      ((next_state == ST_IF1) || (next_state == ST_HALT));
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: registered multicycle control FSM for the RV32I core.
// Holds the state register, the memory wait counter and (when the macro
// MC_CTRL_PERF_CNT_EN is defined) cycle/retire performance counters.
//
// Memory handshake: mem_req is held high for every cycle of a request (IF1,
// IF2, MEM); the request completes in the first IF2/MEM cycle in which
// mem_ready=1. While mem_ready=0 the FSM holds and the wait counter runs;
// reaching MEM_TIMEOUT waiting cycles forces ERR unless mem_ready rises in
// that same cycle.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int STATE_W     = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         part_of_inst,
    input  logic               alu_bcond,
    input  logic               mem_ready,
    output logic [STATE_W-1:0] current_state,
    output logic               ir_write,
    output logic               mem_req,
    output logic               mem_we,
    output logic               rf_we,
    output logic               pc_write,
    output logic               retire,
    output logic               halted,
    output logic               error
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   retire_cnt
`endif
);

    localparam int unsigned TO_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_hit;
    ctrl_strb_t       strb;

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_q == CNT_W'(TO_LAST));

    mc_ctrl_next_state u_next (
        .state       (state_q),
        .opcode      (part_of_inst),
        .alu_bcond   (alu_bcond),
        .mem_ready   (mem_ready),
        .timeout_hit (timeout_hit),
        .next_state  (state_d),
        .strb        (strb)
    );

    // Wait counter: cleared on any state change, counts stalled IF2/MEM cycles.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (((state_q == ST_IF2) || (state_q == ST_MEM)) && !mem_ready
                     && (wait_cnt_q != '1)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IF1;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Strobes are forced low while reset is held so IF1 does not request memory.
    assign current_state = STATE_W'(state_q);
    assign ir_write      = strb.ir_write & reset;
    assign mem_req       = strb.mem_req  & reset;
    assign mem_we        = strb.mem_we   & reset;
    assign rf_we         = strb.rf_we    & reset;
    assign pc_write      = strb.pc_write & reset;
    assign retire        = strb.retire   & reset;
    assign halted        = (state_q == ST_HALT);
    assign error         = (state_q == ST_ERR);

`ifdef MC_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    // Performance counters freeze once the core parks in HALT or ERR.
    always_comb begin
        cycle_cnt_d  = cycle_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if ((state_q != ST_HALT) && (state_q != ST_ERR)) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if (strb.retire) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign cycle_cnt  = cycle_cnt_q;
    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Registered multi-cycle control FSM for the RV32I multicycle core.
- Holds the current state and computes the next state from the opcode and the branch condition.
- Adds a memory-ready handshake with wait states, a wait timeout into an error state, an illegal-opcode trap, and per-state control strobes.
- Sits between the instruction register/decoder and the datapath enables (PC, IR, register file, memory).

Parameters:
- STATE_W, 4, width of the state encoding; must be ≥ 4.
- MEM_TIMEOUT, 16, maximum wait cycles in IF2/MEM before the ERR state; 0 disables the timeout.
- CNT_W, 32, width of the wait counter and the optional performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- part_of_inst  in  7  opcode field; valid in IF2 when mem_ready=1, and held by the IR afterwards.
- alu_bcond  in  1  branch-taken flag; sampled in EX1 only.
- mem_ready  in  1  memory done for the current request.
- current_state  out  STATE_W  registered state.
- ir_write  out  1  latch the instruction.
- mem_req  out  1  memory access request.
- mem_we  out  1  store request.
- rf_we  out  1  register-file write.
- pc_write  out  1  PC update.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  state==HALT.
- error  out  1  state==ERR.

Behaviour:
- State encoding: IF1=0, IF2=1, ID=2, EX1=3, EX2=4, MEM=5, WB=6, HALT=7, ERR=8.
- Reset (reset=0, asynchronous): state=IF1, wait counter=0, all outputs 0, current_state=0.
- IF1 -> IF2 unconditionally. mem_req=1.
- IF2: mem_req=1.
  - mem_ready=0: hold.
  - mem_ready=1: ir_write=1, then:
    - ECALL -> HALT;
    - JAL -> EX1;
    - ARITH, ARITH_IMM, LOAD, STORE, BRANCH, JALR, LUI, AUIPC -> ID;
    - any other opcode -> ERR.
- ID -> EX1.
- EX1:
  - BRANCH with alu_bcond=1 -> EX2.
  - BRANCH with alu_bcond=0 -> IF1, with pc_write=1 (PC+4).
  - ARITH, ARITH_IMM, JAL, JALR, LUI, AUIPC -> WB.
  - LOAD, STORE -> MEM.
  - Any other opcode -> ERR.
- EX2 -> IF1, pc_write=1 (branch target).
- MEM: mem_req=1; mem_we=1 when the opcode is STORE.
  - mem_ready=0: hold.
  - mem_ready=1: LOAD -> WB; STORE -> IF1 with pc_write=1.
- WB -> IF1. rf_we=1, pc_write=1.
- HALT and ERR: absorbing until reset. All strobes are 0 in these states.
- Strobes are combinational from state and inputs (Moore/Mealy mix as stated above); they are 0 in every state not listed.
- retire=1 in the same cycle as each transition into IF1 or HALT.
- Wait counter:
  - cleared on every state change;
  - increments each cycle spent in IF2/MEM with mem_ready=0, saturating at its maximum.
  - When MEM_TIMEOUT≠0 and counter==MEM_TIMEOUT-1 with mem_ready=0, the next state is ERR.
  - mem_ready=1 in the same cycle takes priority over the timeout.
- Reset asserted mid-instruction or mid-wait: immediate return to IF1; no retire pulse.
- alu_bcond outside EX1 and the opcode outside IF2/ID/EX1/MEM are ignored.

Optional Feature:
- Macro: MC_CTRL_PERF_CNT_EN.
- Defined:
  - adds outputs cycle_cnt[CNT_W] (increments every cycle unless halted or error) and retire_cnt[CNT_W] (increments on retire);
  - both reset to 0 and wrap modulo 2^CNT_W.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header: state encodings (IF1..ERR).
- Same shared header: opcode constants ARITHMETIC 0110011, ARITHMETIC_IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, ECALL 1110011, LUI 0110111, AUIPC 0010111.
- One sub-module, mc_ctrl_next_state: purely combinational next state and strobes. The top level holds the state register, wait counter and counters.

Test Plan:
- ADD (0110011), mem_ready=1 always -> states 0,1,2,3,6,0; rf_we high in state 6; one retire; 5 cycles per instruction.
- BRANCH, alu_bcond=1 -> 0,1,2,3,4,0, pc_write in EX2.
- BRANCH, alu_bcond=0 -> 0,1,2,3,0, pc_write in EX1.
- LOAD with mem_ready low 3 cycles in MEM -> MEM held 4 cycles, then WB; mem_we=0 throughout.
- STORE -> mem_we=1 in MEM, then IF1.
- MEM_TIMEOUT=4, mem_ready stuck 0 in IF2 -> ERR after 4 cycles in IF2, error=1 and held.
- mem_ready=1 on the 4th cycle -> proceeds to ID instead.
- ECALL -> HALT after IF2, halted=1 held.
- Opcode 1111111 -> ERR.
- Reset pulsed during MEM wait -> state 0 asynchronously, no retire.
- With MC_CTRL_PERF_CNT_EN: 3 ADDs then ECALL -> retire_cnt=4, cycle_cnt=17, and both freeze in HALT.
